logic_shift_unit: RTL and testbench
===================================

LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 19, meaning the operand/result width in bits (WORD_SIZE generation).
REQ-002 SHALL have localparam SHAMT_W, equal to $clog2(WIDTH) (5 at default), meaning the shift-amount field width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port op  input  3  operation select: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 SHL, 5 SHR, 6 ROL, 7 ROR.
REQ-008 SHALL have port operand_1  input  WIDTH  first operand, or the shift/rotate source.
REQ-009 SHALL have port operand_2  input  WIDTH  second operand; bits [SHAMT_W-1:0] give the shift amount for ops 4-7.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out  output  WIDTH  registered result.
REQ-013 SHALL have port zero_flag  output  1  registered, 1 when out == 0.
REQ-014 SHALL have port parity_flag  output  1  registered XOR-reduction of out.
REQ-015 SHALL have port busy  output  1  high in EXEC state.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-017 SHALL define in_ready as 1 when (state==IDLE) or (state==DONE and out_ready==1), and as 0 otherwise and while rst is high.
REQ-018 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, capturing op, operand_1 and shift amount; later input changes SHALL have no effect.
REQ-019 SHALL, on accepting a logical op (0-3), compute the result, load out, zero_flag and parity_flag, and enter DONE at that edge, so out_valid is high in the next cycle (latency 1).
REQ-020 SHALL ignore operand_2 for NOT.
REQ-021 SHALL, on accepting a shift/rotate op with amount 0, load out = operand_1 and enter DONE at that edge (latency 1).
REQ-022 SHALL, on accepting a shift/rotate op with amount n > 0, load the working register with operand_1 and a counter with n, and enter EXEC.
REQ-023 SHALL, in EXEC, move the working register by one bit per cycle and decrement the counter.
REQ-024 SHALL shift in zeros for SHL and SHR.
REQ-025 SHALL wrap the outgoing bit for ROL and ROR.
REQ-026 SHALL, on the edge where the counter reaches 0, load out and the flags and enter DONE, so out_valid rises n cycles after the accept edge.
REQ-027 SHALL produce result 0 for SHL/SHR with amount >= WIDTH, without special-casing it.
REQ-028 SHALL make ROL/ROR with amount >= WIDTH equivalent to rotating by amount mod WIDTH.
REQ-029 SHALL hold out_valid high and keep out and the flags stable in DONE until out_valid and out_ready are both 1.
REQ-030 SHALL, on that handshake, go to IDLE, or take the simultaneously accepted request (REQ-018) and proceed as REQ-019/021/022 with no bubble.
REQ-031 SHALL hold out_valid at 0 in IDLE and EXEC.
REQ-032 SHALL keep out and the flags holding their last values while out_valid is 0.

Reset
REQ-033 SHALL, while rst is high, force state IDLE and clear out, zero_flag, parity_flag, out_valid, busy, the counter and the working register to 0, independent of clk.
REQ-034 SHALL, on rst assertion in EXEC or DONE, discard the in-flight operation with no result delivered.
REQ-035 SHALL allow a request to be accepted on the first rising edge after rst deasserts (in_ready = 1).

Verification (WIDTH=19)
REQ-036 SHALL be verified by: AND 0x7FFFF, 0x0F0F0 -> out=0x0F0F0, out_valid 1 cycle after accept, zero_flag=0, parity_flag=0.
REQ-037 SHALL be verified by: NOT 0x7FFFF, out_ready=1 -> out=0x00000, zero_flag=1, parity_flag=0; a back-to-back XOR 0x00003, 0x00001 accepted at the handshake edge -> out=0x00002, parity_flag=1.
REQ-038 SHALL be verified by: ROL 0x40001 by 3 -> busy high 3 cycles, out_valid 3 cycles after accept, out=0x0000C, parity_flag=0.
REQ-039 SHALL be verified by: SHL 0x00001 by 25 -> out_valid 25 cycles after accept, out=0, zero_flag=1; ROR 0x00001 by 20 -> out=0x40000.
REQ-040 SHALL be verified by: OR result with out_ready held low 5 cycles -> out_valid, out and flags constant throughout, in_ready=0, new in_valid ignored until out_ready rises.
REQ-041 SHALL be verified by: rst pulsed mid-EXEC of SHR 0x7FFFF by 10 -> out_valid, busy and out go 0 immediately; no result appears; a request is accepted on the first edge after release.

Source files
------------

// File: rtl/logic_shift_unit.sv
// Logic/shift unit: bitwise ops finish in one cycle, while shifts and rotates step
// one bit per cycle. Results wait in DONE until the consumer accepts them.
module logic_shift_unit #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             parity_flag,
    output logic             busy
);

    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q, op_nxt;
    logic [WIDTH-1:0]   work_q, work_nxt;
    logic [SHAMT_W-1:0] cnt_q, cnt_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic               load_out;
    logic               accept;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   step_res;

    assign amt       = operand_2[SHAMT_W-1:0];
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == EXEC);

    // Bitwise result straight from the inputs; only used on the accept edge.
    always_comb begin
        logic_res = '0;
        case (op[1:0])
            2'd0:    logic_res = operand_1 & operand_2;
            2'd1:    logic_res = operand_1 | operand_2;
            2'd2:    logic_res = operand_1 ^ operand_2;
            default: logic_res = ~operand_1;
        endcase
    end

    // One-bit move of the working register, selected by the captured op.
    always_comb begin
        step_res = work_q;
        case (op_q)
            2'd0:    step_res = {work_q[WIDTH-2:0], 1'b0};
            2'd1:    step_res = {1'b0, work_q[WIDTH-1:1]};
            2'd2:    step_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default: step_res = {work_q[0], work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        work_nxt   = work_q;
        cnt_nxt    = cnt_q;
        load_out   = 1'b0;
        result_nxt = out;
        case (state)
            IDLE: begin
            end
            EXEC: begin
                work_nxt = step_res;
                cnt_nxt  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    load_out   = 1'b1;
                    result_nxt = step_res;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A new request can only arrive from IDLE or on the DONE handshake, so it overrides the above.
        if (accept) begin
            op_nxt = op[1:0];
            if (!op[2]) begin
                load_out   = 1'b1;
                result_nxt = logic_res;
                state_nxt  = DONE;
            end else if (amt == '0) begin
                load_out   = 1'b1;
                result_nxt = operand_1;
                state_nxt  = DONE;
            end else begin
                work_nxt  = operand_1;
                cnt_nxt   = amt;
                state_nxt = EXEC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            out         <= '0;
            zero_flag   <= 1'b0;
            parity_flag <= 1'b0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            work_q <= work_nxt;
            cnt_q  <= cnt_nxt;
            if (load_out) begin
                out         <= result_nxt;
                zero_flag   <= ~|result_nxt;
                parity_flag <= ^result_nxt;
            end
        end
    end

endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed bench for logic_shift_unit: stimulus pushes expected results into a
// scoreboard queue, and a negedge monitor checks each result the DUT presents.
module tb_logic_shift_unit;

    localparam int W = 19;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] operand_1 = '0;
    logic [W-1:0] operand_2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         zero_flag;
    logic         parity_flag;
    logic         busy;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int busy_cycles = 0;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic         z;
        logic         p;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    bit   prev_valid = 1'b0;
    bit   prev_hs = 1'b0;

    logic_shift_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .zero_flag   (zero_flag),
        .parity_flag (parity_flag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Latency is the number of edges from the accept edge to the edge that raises out_valid.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        bit   pres;
        if (rst) begin
            acc_q.delete();
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (busy) busy_cycles++;
            pres = out_valid && (!prev_valid || prev_hs);
            if (pres) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                    checkOutput({e.name, "_out"}, out, e.out);
                    checkOutput({e.name, "_zero"}, zero_flag, e.z);
                    checkOutput({e.name, "_parity"}, parity_flag, e.p);
                    checkOutput({e.name, "_latency"}, cyc - a, e.lat);
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] eo, input logic ez, input logic ep, input int elat,
                                 input string nm, input bit expect_res, output int waits);
        exp_t e;
        if (expect_res) begin
            e.name = nm; e.out = eo; e.z = ez; e.p = ep; e.lat = elat;
            exp_q.push_back(e);
        end
        op = o; operand_1 = a; operand_2 = b; in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput({nm, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = ~o; operand_1 = ~a; operand_2 = ~b;
    endtask

    task automatic waitDrain(input string nm);
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int b0;
        #3;
        checkOutput("reset_out", out, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_zero", zero_flag, 0);
        checkOutput("reset_parity", parity_flag, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checkOutput("ready_after_reset", in_ready, 1);

        applyStimulus(3'd0, 19'h7FFFF, 19'h0F0F0, 19'h0F0F0, 1'b0, 1'b0, 0, "and", 1'b1, w);
        waitDrain("and");

        applyStimulus(3'd3, 19'h7FFFF, 19'h00000, 19'h00000, 1'b1, 1'b0, 0, "not", 1'b1, w);
        applyStimulus(3'd2, 19'h00003, 19'h00001, 19'h00002, 1'b0, 1'b1, 0, "xor_b2b", 1'b1, w);
        checkOutput("b2b_no_wait", w, 0);
        waitDrain("b2b");

        applyStimulus(3'd3, 19'h0F0F0, 19'h12345, 19'h70F0F, 1'b0, 1'b1, 0, "not_op2", 1'b1, w);
        waitDrain("not_op2");

        b0 = busy_cycles;
        applyStimulus(3'd6, 19'h40001, 19'd3, 19'h0000C, 1'b0, 1'b0, 3, "rol3", 1'b1, w);
        waitDrain("rol3");
        checkOutput("rol3_busy_cycles", busy_cycles - b0, 3);

        applyStimulus(3'd4, 19'h00001, 19'd25, 19'h00000, 1'b1, 1'b0, 25, "shl25", 1'b1, w);
        waitDrain("shl25");
        applyStimulus(3'd7, 19'h00001, 19'd20, 19'h40000, 1'b0, 1'b1, 20, "ror20", 1'b1, w);
        waitDrain("ror20");
        applyStimulus(3'd6, 19'h00001, 19'd19, 19'h00001, 1'b0, 1'b1, 19, "rol19", 1'b1, w);
        waitDrain("rol19");
        applyStimulus(3'd4, 19'h00001, 19'd18, 19'h40000, 1'b0, 1'b1, 18, "shl18", 1'b1, w);
        waitDrain("shl18");
        applyStimulus(3'd5, 19'h7FFFF, 19'd0, 19'h7FFFF, 1'b0, 1'b1, 0, "shr0", 1'b1, w);
        waitDrain("shr0");
        applyStimulus(3'd5, 19'h7FFFF, 19'd4, 19'h07FFF, 1'b0, 1'b1, 4, "shr4", 1'b1, w);
        waitDrain("shr4");
        applyStimulus(3'd7, 19'h00008, 19'h7FFE3, 19'h00001, 1'b0, 1'b1, 3, "ror_masked", 1'b1, w);
        waitDrain("ror_masked");

        out_ready = 1'b0;
        applyStimulus(3'd1, 19'h12340, 19'h00005, 19'h12345, 1'b0, 1'b1, 0, "or_hold", 1'b1, w);
        in_valid = 1'b1; op = 3'd0; operand_1 = 19'h7FFFF; operand_2 = 19'h00F00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out", out, 19'h12345);
            checkOutput("hold_zero", zero_flag, 0);
            checkOutput("hold_parity", parity_flag, 1);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus(3'd0, 19'h7FFFF, 19'h00F00, 19'h00F00, 1'b0, 1'b0, 0, "and_after_hold", 1'b1, w);
        checkOutput("hold_release_wait", w, 0);
        waitDrain("hold");

        applyStimulus(3'd5, 19'h7FFFF, 19'd10, 19'h0, 1'b0, 1'b0, 10, "shr_abort", 1'b0, w);
        repeat (4) @(posedge clk);
        #1 checkOutput("mid_exec_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out", out, 0);
        checkOutput("abort_in_ready", in_ready, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(3'd0, 19'h0000F, 19'h00003, 19'h00003, 1'b0, 1'b0, 0, "and_post_reset", 1'b1, w);
        checkOutput("post_reset_wait", w, 0);
        repeat (20) @(posedge clk);
        waitDrain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
